vex_pipe: RTL and testbench
===========================

// Module: vex_pipe
// PURPOSE
//  Vector-lane execute stage with valid/ready flow control and a MUL_LATENCY-deep multiply pipeline.
//  Sits between vector issue/operand read and lane writeback.
//  Single-cycle ops go through the lane alu; multiplies go through a pipelined multiplier.
//  Results retire strictly in order. Backpressure from writeback stalls the whole stage.
// PARAMETERS
//  DATA_WIDTH   64  lane datapath width (multiple of 8, >= 64)
//  MICROOP_BIT  9   width of alu_op micro-op field
//  MUL_LATENCY  3   accept-to-output cycles for multiplies (>= 2)
//  REG_ADDR     5   vector register index width
// PORTS
//  clk            in   1             clock
//  rst            in   1             synchronous, active-high reset
//  in_valid       in   1             issue slot holds an op
//  in_ready       out  1             stage accepts op this cycle
//  in_alu_op      in   MICROOP_BIT   micro-op
//  in_is_mul      in   1             op uses multiply path
//  in_dest        in   REG_ADDR      destination vreg
//  in_sew         in   3             element width code
//  in_op1_imm     in   DATA_WIDTH    operand 1, immediate form
//  in_op1_scalar  in   DATA_WIDTH    operand 1, scalar form
//  in_op1_vec     in   DATA_WIDTH    operand 1, vector form
//  in_op2_vec     in   DATA_WIDTH    operand 2, vector
//  in_op3_vec     in   DATA_WIDTH    operand 3 (accumulate / old dest)
//  in_mask_en     in   1             masked op
//  in_mask_bits   in   DATA_WIDTH/8  per-byte mask
//  out_valid      out  1             result register valid
//  out_ready      in   1             writeback accepts result
//  out_dest       out  REG_ADDR      destination vreg
//  out_result     out  DATA_WIDTH    result
//  out_byte_en    out  DATA_WIDTH/8  byte write enables
//  out_sew        out  3             element width code
//  out_op3        out  DATA_WIDTH    operand 3, forwarded for masked merge
//  wait_load_in   in   1             load-pending flag from issue
//  load_dest_in   in   REG_ADDR      load destination
//  wait_load_out  out  1             wait_load_in delayed 1 cycle
//  load_dest_out  out  REG_ADDR      load_dest_in delayed 1 cycle
//  busy           out  1             any op in flight or out_valid
// BEHAVIOUR
//  Reset: every output register and every pipeline valid bit = 0 on the first clk edge with rst=1.
//   In-flight ops are discarded. After reset, in_ready=1 when rst=0.
//  adv = !out_valid || out_ready. When adv=0, all stages hold their contents and in_ready=0.
//  mul_inflight = OR of the multiply-stage valid bits.
//  in_ready = adv && (in_is_mul || !mul_inflight).
//   A non-mul op never overtakes a mul, so retire order stays in order.
//   in_ready depends combinationally on in_is_mul; it never depends on in_valid.
//  Accept = in_valid && in_ready.
//  Non-mul op: result and all sideband fields load into the output register on the accept edge.
//   out_valid=1 the next cycle (latency 1).
//  Mul op: enters mul stage 1. It advances one stage per adv cycle and reaches the output register
//   MUL_LATENCY adv-cycles after accept. Back-to-back muls give 1 op/cycle throughput.
//  ALU and mul retire in the same cycle: impossible by construction.
//   The bench asserts one-hot of {alu_retire, mul_retire}.
//  out_byte_en = in_mask_en ? (alu masked_write_back gating of in_mask_bits) : all ones.
//   A masked op whose mask is all zeros still retires, with out_byte_en=0.
//  out_valid falls when out_ready=1 and no new retire is pending.
//   If a new retire is pending in that cycle, out_valid stays 1 with the new contents.
//  wait_load_out and load_dest_out are plain 1-cycle delays; they ignore adv.
//  Multiply arithmetic is SEW-partitioned. Products are truncated to the element width (low half).
//  busy = out_valid || mul_inflight.
// STRUCTURE
//  Shared package vex_pkg: sew_e enum, vex_req_t (op fields and sideband), vex_rsp_t (output fields),
//   MUL_LATENCY_MIN constant.
//  Sub-module vex_mul_pipe: SEW-partitioned multiplier. It carries sideband valid/dest/sew/op3/byte_en
//   along its stages and has an enable input driven by adv.
//  The existing lane alu is instantiated for non-mul ops.
// TESTING
//  1 ADD sew=64, op1_vec=5, op2_vec=7, out_ready=1 -> out_valid next cycle, out_result=12, out_byte_en=8'hFF.
//  2 MUL, op1=3, op2=4, then ADD 1+1 on the next cycle (MUL_LATENCY=3)
//     -> in_ready=0 for the ADD for 2 cycles; outputs arrive in order 12 then 2.
//  3 Four back-to-back MULs -> four consecutive out_valid cycles, accept-to-out = 3 cycles.
//  4 out_ready=0 for 5 cycles with 2 ops in flight -> in_ready=0; out_result holds; no op is lost or duplicated.
//  5 Masked ADD, mask_bits=8'h0F -> out_byte_en=8'h0F, out_op3 = in_op3_vec.
//  6 rst=1 with a MUL in stage 2 -> next cycle out_valid=0, busy=0, wait_load_out=0; the dropped MUL never appears.

Source files
------------

// File: rtl/vex_pkg.sv
// Shared types and helpers for the vector-lane execute stage.
package vex_pkg;

   localparam int VEX_DATA_WIDTH  = 64;
   localparam int VEX_MICROOP_BIT = 9;
   localparam int VEX_REG_ADDR    = 5;
   localparam int VEX_BYTES       = VEX_DATA_WIDTH / 8;
   localparam int MUL_LATENCY_MIN = 2;

   // Element width code carried with every op.
   typedef enum logic [2:0] {
      SEW_8  = 3'd0,
      SEW_16 = 3'd1,
      SEW_32 = 3'd2,
      SEW_64 = 3'd3
   } sew_e;

   // Micro-op layout: top two bits pick operand 1, low bits pick the lane function.
   typedef enum logic [1:0] {
      OP1_VEC    = 2'd0,
      OP1_SCALAR = 2'd1,
      OP1_IMM    = 2'd2
   } op1_src_e;

   typedef enum logic [VEX_MICROOP_BIT-3:0] {
      ALU_ADD  = 7'd0,
      ALU_SUB  = 7'd1,
      ALU_AND  = 7'd2,
      ALU_OR   = 7'd3,
      ALU_XOR  = 7'd4,
      ALU_MOV2 = 7'd5
   } alu_fn_e;

   typedef enum logic [1:0] {
      ARITH_ADD = 2'd0,
      ARITH_SUB = 2'd1,
      ARITH_MUL = 2'd2
   } arith_e;

   // Op fields and sideband as presented by issue.
   typedef struct packed {
      logic [VEX_MICROOP_BIT-1:0] alu_op;
      logic [VEX_REG_ADDR-1:0]    dest;
      logic [2:0]                 sew;
      logic [VEX_DATA_WIDTH-1:0]  op1_imm;
      logic [VEX_DATA_WIDTH-1:0]  op1_scalar;
      logic [VEX_DATA_WIDTH-1:0]  op1_vec;
      logic [VEX_DATA_WIDTH-1:0]  op2;
      logic [VEX_DATA_WIDTH-1:0]  op3;
      logic                       mask_en;
      logic [VEX_BYTES-1:0]       mask_bits;
   } vex_req_t;

   // Fields written back to the lane.
   typedef struct packed {
      logic [VEX_REG_ADDR-1:0]   dest;
      logic [2:0]                sew;
      logic [VEX_DATA_WIDTH-1:0] result;
      logic [VEX_BYTES-1:0]      byte_en;
      logic [VEX_DATA_WIDTH-1:0] op3;
   } vex_rsp_t;

   // Element-partitioned add/sub/mul; every element result is truncated to its width.
   // Reserved width codes fall back to full 64-bit elements.
   function automatic logic [VEX_DATA_WIDTH-1:0] sew_arith(
      input logic [VEX_DATA_WIDTH-1:0] a,
      input logic [VEX_DATA_WIDTH-1:0] b,
      input sew_e                      sew,
      input arith_e                    kind
   );
      logic [VEX_DATA_WIDTH-1:0] r;
      r = '0;
      case (sew)
         SEW_8:
            for (int i = 0; i < VEX_DATA_WIDTH / 8; i++)
               case (kind)
                  ARITH_ADD: r[i*8 +: 8] = a[i*8 +: 8] + b[i*8 +: 8];
                  ARITH_SUB: r[i*8 +: 8] = a[i*8 +: 8] - b[i*8 +: 8];
                  default:   r[i*8 +: 8] = a[i*8 +: 8] * b[i*8 +: 8];
               endcase
         SEW_16:
            for (int i = 0; i < VEX_DATA_WIDTH / 16; i++)
               case (kind)
                  ARITH_ADD: r[i*16 +: 16] = a[i*16 +: 16] + b[i*16 +: 16];
                  ARITH_SUB: r[i*16 +: 16] = a[i*16 +: 16] - b[i*16 +: 16];
                  default:   r[i*16 +: 16] = a[i*16 +: 16] * b[i*16 +: 16];
               endcase
         SEW_32:
            for (int i = 0; i < VEX_DATA_WIDTH / 32; i++)
               case (kind)
                  ARITH_ADD: r[i*32 +: 32] = a[i*32 +: 32] + b[i*32 +: 32];
                  ARITH_SUB: r[i*32 +: 32] = a[i*32 +: 32] - b[i*32 +: 32];
                  default:   r[i*32 +: 32] = a[i*32 +: 32] * b[i*32 +: 32];
               endcase
         default:
            for (int i = 0; i < VEX_DATA_WIDTH / 64; i++)
               case (kind)
                  ARITH_ADD: r[i*64 +: 64] = a[i*64 +: 64] + b[i*64 +: 64];
                  ARITH_SUB: r[i*64 +: 64] = a[i*64 +: 64] - b[i*64 +: 64];
                  default:   r[i*64 +: 64] = a[i*64 +: 64] * b[i*64 +: 64];
               endcase
      endcase
      return r;
   endfunction

endpackage

// File: rtl/vex_alu.sv
// Lane ALU for single-cycle ops: operand-1 select, lane function, write-enable gating.
module vex_alu
   import vex_pkg::*;
(
   input  vex_req_t                  i_req,
   output logic [VEX_DATA_WIDTH-1:0] o_op1,
   output vex_rsp_t                  o_rsp
);

   op1_src_e                  w_src;
   alu_fn_e                   w_fn;
   logic [VEX_DATA_WIDTH-1:0] w_result;
   logic [VEX_BYTES-1:0]      w_byte_en;

   assign w_src = op1_src_e'(i_req.alu_op[VEX_MICROOP_BIT-1 -: 2]);
   assign w_fn  = alu_fn_e'(i_req.alu_op[VEX_MICROOP_BIT-3:0]);

   // Pick the operand-1 form; the multiply path shares this selection.
   always_comb begin
      case (w_src)
         OP1_SCALAR: o_op1 = i_req.op1_scalar;
         OP1_IMM:    o_op1 = i_req.op1_imm;
         default:    o_op1 = i_req.op1_vec;
      endcase
   end

   // Lane function; unknown codes pass operand 1 through.
   always_comb begin
      // NOTE: assign a default first so every path drives w_result and no latch is inferred.
      w_result = o_op1;
      case (w_fn)
         ALU_ADD:  w_result = sew_arith(o_op1, i_req.op2, sew_e'(i_req.sew), ARITH_ADD);
         ALU_SUB:  w_result = sew_arith(o_op1, i_req.op2, sew_e'(i_req.sew), ARITH_SUB);
         ALU_AND:  w_result = o_op1 & i_req.op2;
         ALU_OR:   w_result = o_op1 | i_req.op2;
         ALU_XOR:  w_result = o_op1 ^ i_req.op2;
         ALU_MOV2: w_result = i_req.op2;
         default:  ;
      endcase
   end

   // Masked ops write only the enabled bytes; an all-zero mask still retires.
   assign w_byte_en = i_req.mask_en ? i_req.mask_bits : {VEX_BYTES{1'b1}};

   assign o_rsp = '{dest:    i_req.dest,
                    sew:     i_req.sew,
                    result:  w_result,
                    byte_en: w_byte_en,
                    op3:     i_req.op3};

endmodule

// File: rtl/vex_mul_pipe.sv
// Element-partitioned multiplier with STAGES register stages; sideband travels alongside.
module vex_mul_pipe
   import vex_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_en,
   input  logic                      i_valid,
   input  logic [VEX_DATA_WIDTH-1:0] i_a,
   input  logic [VEX_DATA_WIDTH-1:0] i_b,
   input  logic [2:0]                i_sew,
   input  logic [VEX_REG_ADDR-1:0]   i_dest,
   input  logic [VEX_DATA_WIDTH-1:0] i_op3,
   input  logic [VEX_BYTES-1:0]      i_byte_en,
   output logic                      o_valid,
   output logic                      o_inflight,
   output vex_rsp_t                  o_rsp
);

   logic [STAGES-1:0] r_valid;
   vex_rsp_t          r_stage [STAGES];

   // Stage valid bits shift forward whenever the stage may advance.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every stage samples its predecessor's old value.
      if (rst) begin
         r_valid <= '0;
      end else if (i_en) begin
         r_valid[0] <= i_valid;
         for (int s = 1; s < STAGES; s++) r_valid[s] <= r_valid[s-1];
      end
   end

   // Product and sideband follow the valid bits.
   always_ff @(posedge clk) begin
      // NOTE: datapath stages have no reset; the valid bits alone decide whether a stage is live.
      if (i_en) begin
         r_stage[0] <= '{dest:    i_dest,
                         sew:     i_sew,
                         result:  sew_arith(i_a, i_b, sew_e'(i_sew), ARITH_MUL),
                         byte_en: i_byte_en,
                         op3:     i_op3};
         for (int s = 1; s < STAGES; s++) r_stage[s] <= r_stage[s-1];
      end
   end

   assign o_valid    = r_valid[STAGES-1];
   assign o_inflight = |r_valid;
   assign o_rsp      = r_stage[STAGES-1];

endmodule

// File: rtl/vex_pipe.sv
// Vector-lane execute stage: lane ALU plus pipelined multiplier, in-order retire, valid/ready.
// Internal bundles use the package widths, so the width parameters must keep their defaults.
module vex_pipe
   import vex_pkg::*;
#(
   parameter int DATA_WIDTH  = VEX_DATA_WIDTH,
   parameter int MICROOP_BIT = VEX_MICROOP_BIT,
   parameter int MUL_LATENCY = 3,
   parameter int REG_ADDR    = VEX_REG_ADDR
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [MICROOP_BIT-1:0]  in_alu_op,
   input  logic                    in_is_mul,
   input  logic [REG_ADDR-1:0]     in_dest,
   input  logic [2:0]              in_sew,
   input  logic [DATA_WIDTH-1:0]   in_op1_imm,
   input  logic [DATA_WIDTH-1:0]   in_op1_scalar,
   input  logic [DATA_WIDTH-1:0]   in_op1_vec,
   input  logic [DATA_WIDTH-1:0]   in_op2_vec,
   input  logic [DATA_WIDTH-1:0]   in_op3_vec,
   input  logic                    in_mask_en,
   input  logic [DATA_WIDTH/8-1:0] in_mask_bits,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [REG_ADDR-1:0]     out_dest,
   output logic [DATA_WIDTH-1:0]   out_result,
   output logic [DATA_WIDTH/8-1:0] out_byte_en,
   output logic [2:0]              out_sew,
   output logic [DATA_WIDTH-1:0]   out_op3,
   input  logic                    wait_load_in,
   input  logic [REG_ADDR-1:0]     load_dest_in,
   output logic                    wait_load_out,
   output logic [REG_ADDR-1:0]     load_dest_out,
   output logic                    busy
);

   vex_req_t              w_req;
   vex_rsp_t              w_alu_rsp;
   vex_rsp_t              w_mul_rsp;
   logic [DATA_WIDTH-1:0] w_op1;
   logic                  w_adv;
   logic                  w_accept;
   logic                  w_alu_retire;
   logic                  w_mul_accept;
   logic                  w_mul_valid;
   logic                  w_mul_retire;
   logic                  w_mul_inflight;

   logic                  r_out_valid;
   vex_rsp_t              r_rsp;
   logic                  r_wait_load;
   logic [REG_ADDR-1:0]   r_load_dest;

   // Everything moves only when the output register is free or being drained.
   assign w_adv = !r_out_valid || out_ready;

   // A non-mul op waits for the multiplier to empty so it cannot overtake a multiply.
   assign in_ready     = w_adv && (in_is_mul || !w_mul_inflight);
   assign w_accept     = in_valid && in_ready;
   assign w_alu_retire = w_accept && !in_is_mul;
   assign w_mul_accept = w_accept && in_is_mul;
   assign w_mul_retire = w_mul_valid && w_adv;

   assign w_req = '{alu_op:     in_alu_op,
                    dest:       in_dest,
                    sew:        in_sew,
                    op1_imm:    in_op1_imm,
                    op1_scalar: in_op1_scalar,
                    op1_vec:    in_op1_vec,
                    op2:        in_op2_vec,
                    op3:        in_op3_vec,
                    mask_en:    in_mask_en,
                    mask_bits:  in_mask_bits};

   vex_alu u_alu (
      .i_req (w_req),
      .o_op1 (w_op1),
      .o_rsp (w_alu_rsp)
   );

   // The output register is the last of the MUL_LATENCY stages.
   vex_mul_pipe #(
      .STAGES (MUL_LATENCY - 1)
   ) u_mul (
      .clk        (clk),
      .rst        (rst),
      .i_en       (w_adv),
      .i_valid    (w_mul_accept),
      .i_a        (w_op1),
      .i_b        (in_op2_vec),
      .i_sew      (in_sew),
      .i_dest     (in_dest),
      .i_op3      (in_op3_vec),
      .i_byte_en  (w_alu_rsp.byte_en),
      .o_valid    (w_mul_valid),
      .o_inflight (w_mul_inflight),
      .o_rsp      (w_mul_rsp)
   );

   // Output register: load the retiring op, otherwise drop valid once writeback takes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_rsp       <= '0;
      end else if (w_adv) begin
         r_out_valid <= w_alu_retire || w_mul_retire;
         if (w_alu_retire) begin
            r_rsp <= w_alu_rsp;
         end else if (w_mul_retire) begin
            r_rsp <= w_mul_rsp;
         end
      end
   end

   // Load-pending flag and destination are a plain one-cycle delay, independent of flow control.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wait_load <= 1'b0;
         r_load_dest <= '0;
      end else begin
         r_wait_load <= wait_load_in;
         r_load_dest <= load_dest_in;
      end
   end

   assign out_valid     = r_out_valid;
   assign out_dest      = r_rsp.dest;
   assign out_result    = r_rsp.result;
   assign out_byte_en   = r_rsp.byte_en;
   assign out_sew       = r_rsp.sew;
   assign out_op3       = r_rsp.op3;
   assign wait_load_out = r_wait_load;
   assign load_dest_out = r_load_dest;
   assign busy          = r_out_valid || w_mul_inflight;

endmodule

// File: tb/tb_vex_pipe.sv
// Scoreboard bench for vex_pipe: expectations pushed at accept, compared at writeback handshake.
module tb_vex_pipe;

   localparam int DW = 64;
   localparam int NB = DW / 8;
   localparam int RA = 5;
   localparam int MB = 9;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, in_is_mul, in_mask_en;
   logic [MB-1:0] in_alu_op;
   logic [RA-1:0] in_dest;
   logic [2:0]    in_sew;
   logic [DW-1:0] in_op1_imm, in_op1_scalar, in_op1_vec, in_op2_vec, in_op3_vec;
   logic [NB-1:0] in_mask_bits;
   logic          out_valid, out_ready;
   logic [RA-1:0] out_dest;
   logic [DW-1:0] out_result, out_op3;
   logic [NB-1:0] out_byte_en;
   logic [2:0]    out_sew;
   logic          wait_load_in, wait_load_out, busy;
   logic [RA-1:0] load_dest_in, load_dest_out;

   always #5 clk = ~clk;

   vex_pipe #(
      .DATA_WIDTH (DW), .MICROOP_BIT (MB), .MUL_LATENCY (3), .REG_ADDR (RA)
   ) dut (
      .clk (clk), .rst (rst),
      .in_valid (in_valid), .in_ready (in_ready), .in_alu_op (in_alu_op), .in_is_mul (in_is_mul),
      .in_dest (in_dest), .in_sew (in_sew), .in_op1_imm (in_op1_imm), .in_op1_scalar (in_op1_scalar),
      .in_op1_vec (in_op1_vec), .in_op2_vec (in_op2_vec), .in_op3_vec (in_op3_vec),
      .in_mask_en (in_mask_en), .in_mask_bits (in_mask_bits),
      .out_valid (out_valid), .out_ready (out_ready), .out_dest (out_dest), .out_result (out_result),
      .out_byte_en (out_byte_en), .out_sew (out_sew), .out_op3 (out_op3),
      .wait_load_in (wait_load_in), .load_dest_in (load_dest_in),
      .wait_load_out (wait_load_out), .load_dest_out (load_dest_out), .busy (busy)
   );

   typedef struct {
      logic [RA-1:0] dest;
      logic [DW-1:0] result;
      logic [NB-1:0] byte_en;
      logic [2:0]    sew;
      logic [DW-1:0] op3;
      int            acc_cyc;
      int            lat;
      bit            chk_lat;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   bit   lat_chk  = 1'b1;
   bit   stream_done;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference arithmetic: walk the word element by element with shifts and masks.
   function automatic logic [63:0] m_arith(input logic [63:0] a, input logic [63:0] b,
                                           input logic [2:0] sew, input int kind);
      int          ew;
      logic [63:0] msk, r, x, y, z;
      ew  = 8 << sew;
      msk = (ew == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << ew) - 64'd1);
      r   = '0;
      for (int off = 0; off < 64; off += ew) begin
         x = (a >> off) & msk;
         y = (b >> off) & msk;
         case (kind)
            0:       z = x + y;
            1:       z = x - y;
            default: z = x * y;
         endcase
         r = r | ((z & msk) << off);
      end
      return r;
   endfunction

   function automatic exp_t m_expect();
      exp_t        e;
      logic [63:0] a;
      a = (in_alu_op[8:7] == 2'd1) ? in_op1_scalar :
          (in_alu_op[8:7] == 2'd2) ? in_op1_imm : in_op1_vec;
      if (in_is_mul) e.result = m_arith(a, in_op2_vec, in_sew, 2);
      else case (in_alu_op[6:0])
         7'd0:    e.result = m_arith(a, in_op2_vec, in_sew, 0);
         7'd1:    e.result = m_arith(a, in_op2_vec, in_sew, 1);
         7'd2:    e.result = a & in_op2_vec;
         7'd3:    e.result = a | in_op2_vec;
         7'd4:    e.result = a ^ in_op2_vec;
         7'd5:    e.result = in_op2_vec;
         default: e.result = a;
      endcase
      e.dest    = in_dest;
      e.byte_en = in_mask_en ? in_mask_bits : 8'hFF;
      e.sew     = in_sew;
      e.op3     = in_op3_vec;
      e.acc_cyc = cyc;
      e.lat     = in_is_mul ? 3 : 1;
      e.chk_lat = lat_chk;
      return e;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare at handshake, then record whatever is accepted this cycle.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            check("sb_nonempty", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("out_result", out_result, e.result);
               check("out_byte_en", out_byte_en, e.byte_en);
               check("out_dest", out_dest, e.dest);
               check("out_sew", out_sew, e.sew);
               check("out_op3", out_op3, e.op3);
               if (e.chk_lat) check("latency", cyc - e.acc_cyc, e.lat);
            end
         end
         if (in_valid && in_ready) sb.push_back(m_expect());
         if (dut.w_alu_retire || dut.w_mul_retire)
            check("retire_onehot", $onehot({dut.w_alu_retire, dut.w_mul_retire}), 1'b1);
      end
   end

   // Present one op and hold it until accepted; returns the number of refused cycles.
   task automatic drive_op(input bit is_mul, input logic [6:0] fn, input logic [1:0] src,
                           input logic [2:0] sew, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] op3, input bit men, input logic [7:0] mbits,
                           output int stalls);
      bit acc;
      in_op1_vec    = {$urandom, $urandom};
      in_op1_scalar = {$urandom, $urandom};
      in_op1_imm    = {$urandom, $urandom};
      case (src)
         2'd1:    in_op1_scalar = a;
         2'd2:    in_op1_imm    = a;
         default: in_op1_vec    = a;
      endcase
      in_valid = 1'b1; in_is_mul = is_mul; in_alu_op = {src, fn}; in_sew = sew;
      in_op2_vec = b; in_op3_vec = op3; in_mask_en = men; in_mask_bits = mbits;
      in_dest = 5'($urandom);
      stalls = 0;
      forever begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc) break;
         stalls++;
         if (stalls > 60) begin
            check("accept_timeout", acc, 1'b1);
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int k;
      for (k = 0; k < 100; k++) begin
         @(posedge clk);
         #2;
         if (sb.size() == 0 && !busy) break;
      end
      check("drain_sb_empty", sb.size(), 0);
      check("drain_busy", busy, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int st, tot;
      logic [63:0] prod_a;
      rst = 1'b1; in_valid = 1'b0; in_is_mul = 1'b0; in_alu_op = '0; in_dest = '0; in_sew = 3'd3;
      in_op1_imm = '0; in_op1_scalar = '0; in_op1_vec = '0; in_op2_vec = '0; in_op3_vec = '0;
      in_mask_en = 1'b0; in_mask_bits = '0; out_ready = 1'b1; wait_load_in = 1'b0; load_dest_in = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_busy", busy, 1'b0);
      check("reset_in_ready", in_ready, 1'b1);
      check("reset_wait_load_out", wait_load_out, 1'b0);

      // ADD 5+7, full width
      drive_op(0, 7'd0, 2'd0, 3'd3, 64'd5, 64'd7, 64'h1234, 0, 8'h00, st);
      check("t1_out_valid", out_valid, 1'b1);
      check("t1_out_result", out_result, 64'd12);
      check("t1_out_byte_en", out_byte_en, 8'hFF);
      drain();

      // MUL 3*4 then ADD 1+1: the ADD waits two cycles, results in order
      drive_op(1, 7'd0, 2'd0, 3'd3, 64'd3, 64'd4, 64'h0, 0, 8'h00, st);
      drive_op(0, 7'd0, 2'd0, 3'd3, 64'd1, 64'd1, 64'h0, 0, 8'h00, st);
      check("t2_add_stalls", st, 2);
      drain();

      // Four back-to-back MULs at several element widths
      tot = 0;
      for (int i = 0; i < 4; i++) begin
         drive_op(1, 7'd0, 2'(i % 3), 3'(i), {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, 0, 8'h00, st);
         tot += st;
      end
      check("t3_mul_stalls", tot, 0);
      drain();

      // Masked, selected-operand and partitioned ALU cases
      drive_op(0, 7'd0, 2'd0, 3'd3, 64'd9, 64'd6, 64'hDEAD_BEEF_0BAD_F00D, 1, 8'h0F, st);
      drive_op(0, 7'd0, 2'd0, 3'd3, 64'd2, 64'd2, 64'h55, 1, 8'h00, st);
      drive_op(0, 7'd1, 2'd1, 3'd1, 64'h0001_0005_0000_0003, 64'h0002_0001_0001_0004, 64'h0, 0, 8'h00, st);
      drive_op(0, 7'd0, 2'd2, 3'd0, 64'hFF01_0203_0405_0607, 64'h0101_0101_0101_0101, 64'h0, 0, 8'h00, st);
      drive_op(0, 7'd4, 2'd1, 3'd3, 64'hF0F0_F0F0_0000_FFFF, 64'h0FF0_0FF0_FFFF_FFFF, 64'h0, 0, 8'h00, st);
      drive_op(0, 7'd3, 2'd2, 3'd2, 64'h1, 64'h8000_0000_0000_0000, 64'h0, 1, 8'hA5, st);
      drive_op(0, 7'd5, 2'd0, 3'd3, 64'h7, 64'h9999, 64'h0, 0, 8'h00, st);
      drive_op(1, 7'd0, 2'd0, 3'd0, 64'h1011_1213_1415_1617, 64'h0F0E_0D0C_0B0A_0908, 64'h1, 1, 8'h3C, st);
      drain();

      // Writeback stall with two MULs in flight
      lat_chk = 1'b0;
      prod_a = m_arith(64'h1_0000_0003, 64'h7, 3'd3, 2);
      drive_op(1, 7'd0, 2'd0, 3'd3, 64'h1_0000_0003, 64'h7, 64'h0, 0, 8'h00, st);
      drive_op(1, 7'd0, 2'd0, 3'd3, 64'h11, 64'h11, 64'h0, 0, 8'h00, st);
      out_ready = 1'b0;
      in_is_mul = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         if (k >= 1) begin
            check("t4_in_ready_stalled", in_ready, 1'b0);
            check("t4_result_hold", out_result, prod_a);
            check("t4_busy", busy, 1'b1);
         end
      end
      out_ready = 1'b1;
      in_is_mul = 1'b0;
      drain();

      // Random mixed stream under random writeback backpressure
      stream_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 24; i++)
               drive_op(1'($urandom_range(0, 1)), 7'($urandom_range(0, 5)), 2'($urandom_range(0, 2)),
                        3'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
                        {$urandom, $urandom}, 1'($urandom_range(0, 1)), 8'($urandom), st);
            stream_done = 1'b1;
         end
         begin
            while (!stream_done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      drain();
      lat_chk = 1'b1;

      // Reset with a MUL in stage 2: it is dropped and the load flags clear
      drive_op(1, 7'd0, 2'd0, 3'd3, 64'd6, 64'd7, 64'h0, 0, 8'h00, st);
      @(posedge clk);
      #1;
      wait_load_in = 1'b1;
      load_dest_in = 5'h13;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("t6_out_valid", out_valid, 1'b0);
      check("t6_busy", busy, 1'b0);
      check("t6_wait_load_out", wait_load_out, 1'b0);
      check("t6_load_dest_out", load_dest_out, 5'h00);
      @(posedge clk);
      #1;
      wait_load_in = 1'b0;
      check("t6_wait_load_delay", wait_load_out, 1'b1);
      check("t6_load_dest_delay", load_dest_out, 5'h13);
      @(posedge clk);
      #1;
      check("t6_wait_load_fall", wait_load_out, 1'b0);
      repeat (6) @(posedge clk);
      #1;
      check("t6_no_ghost_valid", out_valid, 1'b0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
